// File: rtl/can_pkg.sv
// Shared definitions for the CAN bridge transmit/receive paths: field widths,
// FSM state encoding (also reported on statev) and the CRC-15 step.
package can_pkg;

  localparam int                  ID_BITS   = 11;
  localparam int                  CRC_BITS  = 15;
  localparam logic [CRC_BITS-1:0] CRC_POLY  = 15'h4599;
  localparam int                  EOF_BITS  = 7;
  localparam int                  MAX_BYTES = 8;
  localparam int                  CNT_W     = 4;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_SOF  = 4'd1,
    S_ID   = 4'd2,
    S_CTRL = 4'd3,
    S_DATA = 4'd4,
    S_CRC  = 4'd5,
    S_ACK  = 4'd6,
    S_EOF  = 4'd7
  } state_t;

  // Control byte as it appears on the wire, MSB first.
  typedef struct packed {
    logic [3:0] reserved;
    logic [3:0] dlc;
  } ctrl_t;

  function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
    return (dlc > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : dlc;
  endfunction

  function automatic logic [CRC_BITS-1:0] crc15_next(input logic [CRC_BITS-1:0] crc,
                                                    input logic                b);
    return {crc[CRC_BITS-2:0], 1'b0} ^ ((b ^ crc[CRC_BITS-1]) ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Bit-serial CAN CRC-15 accumulator; shared by the transmitter and receiver.
module can_crc15
  import can_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                bit_en,
  input  logic                bit_in,
  output logic [CRC_BITS-1:0] crc
);

  logic [CRC_BITS-1:0] r_crc;

  // NOTE: clocked state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_crc <= '0;
    end else if (bit_en) begin
      r_crc <= crc15_next(r_crc, bit_in);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/can_tx.sv
// Bit-serial CAN frame transmitter: SOF, ID, control byte, payload, CRC-15,
// ACK and EOF, one bit per T_frame strobe, fed through a one-byte holding register.
module can_tx
  import can_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               T_frame,
  input  logic               Can_tx_start,
  input  logic [ID_BITS-1:0] Can_tx_id,
  input  logic [3:0]         Can_tx_dlc,
  input  logic [7:0]         Can_tx_data_Bus,
  input  logic               Can_tx_data_valid,
  output logic               Can_tx_data_ready,
  output logic               Can_tx,
  output logic               Can_tx_busy,
  output logic               Can_tx_done,
  output logic               Can_tx_error,
  output logic [3:0]         statev
);

  state_t              r_state, w_next_state;
  logic                r_tx, r_done, r_error, r_full;
  logic [ID_BITS-1:0]  r_id;
  logic [3:0]          r_dlc;
  logic [CNT_W-1:0]    r_bit_cnt, r_byte_cnt;
  logic [7:0]          r_hold, r_shift;

  logic                w_accept, w_bit, w_crc_en, w_load_byte, w_underrun, w_finish;
  logic                w_cnt_clr, w_cnt_inc, w_byte_inc;
  logic [3:0]          w_nbytes;
  logic [CRC_BITS-1:0] w_crc;
  ctrl_t               w_ctrl;
  logic [CNT_W-1:0]    w_id_idx, w_crc_idx;
  logic [2:0]          w_bit_idx;

  assign w_accept  = (r_state == S_IDLE) && Can_tx_start;
  assign w_nbytes  = clamp_dlc(r_dlc);
  assign w_ctrl    = '{reserved: 4'b0000, dlc: r_dlc};
  assign w_id_idx  = CNT_W'(ID_BITS - 1) - r_bit_cnt;
  assign w_crc_idx = CNT_W'(CRC_BITS - 1) - r_bit_cnt;
  assign w_bit_idx = ~r_bit_cnt[2:0];

  can_crc15 u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_accept),
    .bit_en (w_crc_en),
    .bit_in (w_bit),
    .crc    (w_crc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The state names the field whose next bit goes out on the coming strobe.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_bit        = 1'b1;
    w_crc_en     = 1'b0;
    w_load_byte  = 1'b0;
    w_underrun   = 1'b0;
    w_finish     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_byte_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Can_tx_start) w_next_state = S_SOF;
      end
      S_SOF: begin
        if (T_frame) begin
          w_bit        = 1'b0;
          w_crc_en     = 1'b1;
          w_cnt_clr    = 1'b1;
          w_next_state = S_ID;
        end
      end
      S_ID: begin
        if (T_frame) begin
          w_bit    = r_id[w_id_idx];
          w_crc_en = 1'b1;
          if (r_bit_cnt == CNT_W'(ID_BITS - 1)) begin
            w_cnt_clr    = 1'b1;
            w_next_state = S_CTRL;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_CTRL: begin
        if (T_frame) begin
          w_bit    = w_ctrl[w_bit_idx];
          w_crc_en = 1'b1;
          if (r_bit_cnt == CNT_W'(7)) begin
            w_cnt_clr    = 1'b1;
            w_next_state = (w_nbytes == 4'd0) ? S_CRC : S_DATA;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (T_frame) begin
          if (r_bit_cnt == '0 && !r_full) begin
            w_underrun   = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_crc_en = 1'b1;
            if (r_bit_cnt == '0) begin
              w_load_byte = 1'b1;
              w_bit       = r_hold[7];
            end else begin
              w_bit = r_shift[w_bit_idx];
            end
            if (r_bit_cnt == CNT_W'(7)) begin
              w_cnt_clr  = 1'b1;
              w_byte_inc = 1'b1;
              if (r_byte_cnt == w_nbytes - 4'd1) w_next_state = S_CRC;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end
        end
      end
      S_CRC: begin
        if (T_frame) begin
          w_bit = w_crc[w_crc_idx];
          if (r_bit_cnt == CNT_W'(CRC_BITS - 1)) begin
            w_cnt_clr    = 1'b1;
            w_next_state = S_ACK;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_ACK: begin
        if (T_frame) begin
          w_cnt_clr    = 1'b1;
          w_next_state = S_EOF;
        end
      end
      S_EOF: begin
        if (T_frame) begin
          if (r_bit_cnt == CNT_W'(EOF_BITS)) begin
            w_finish     = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_full     <= 1'b0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_done  <= w_finish;
      r_error <= w_underrun;
      if (T_frame && r_state != S_IDLE) r_tx <= w_bit;

      if (w_accept || w_cnt_clr) r_bit_cnt <= '0;
      else if (w_cnt_inc)        r_bit_cnt <= r_bit_cnt + 1'b1;

      if (w_accept)        r_byte_cnt <= '0;
      else if (w_byte_inc) r_byte_cnt <= r_byte_cnt + 1'b1;

      // Completion and abort flush a byte still waiting in the holding register.
      if (w_finish || w_underrun || w_load_byte) r_full <= 1'b0;
      else if (Can_tx_data_valid && !r_full)     r_full <= 1'b1;
    end
  end

  // NOTE: payload and latched-request registers carry no reset; they are only
  // read after a fresh start or a full flag qualifies them.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_id  <= Can_tx_id;
      r_dlc <= Can_tx_dlc;
    end
    if (Can_tx_data_valid && !r_full) r_hold <= Can_tx_data_Bus;
    if (w_load_byte) r_shift <= r_hold;
  end

  assign Can_tx_data_ready = ~r_full;
  assign Can_tx            = r_tx;
  assign Can_tx_busy       = (r_state != S_IDLE);
  assign Can_tx_done       = r_done;
  assign Can_tx_error      = r_error;
  assign statev            = r_state;

endmodule

// File: tb/tb_can_tx.sv
// Scoreboard bench for can_tx: expected frames come from a field-level model
// with CRC by polynomial long division; a monitor captures one bit per strobe.
module tb_can_tx;

  localparam int K_DONE  = 0;
  localparam int K_ERR   = 1;
  localparam int K_ABORT = 2;

  typedef struct packed {
    logic [255:0] bits;   // bits[i] = value expected after the (i+1)-th in-frame strobe
    logic [31:0]  kind;
    logic [31:0]  nbits;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        T_frame = 1'b0;
  logic        Can_tx_start = 1'b0;
  logic [10:0] Can_tx_id = '0;
  logic [3:0]  Can_tx_dlc = '0;
  logic [7:0]  Can_tx_data_Bus = '0;
  logic        Can_tx_data_valid = 1'b0;
  logic        Can_tx_data_ready, Can_tx, Can_tx_busy, Can_tx_done, Can_tx_error;
  logic [3:0]  statev;

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [7:0]  feed_q[$];
  bit          rnd_strobe = 1'b0;
  logic [14:0] poly_v = 15'h4599;

  can_tx dut (
    .clock             (clock),
    .reset             (reset),
    .T_frame           (T_frame),
    .Can_tx_start      (Can_tx_start),
    .Can_tx_id         (Can_tx_id),
    .Can_tx_dlc        (Can_tx_dlc),
    .Can_tx_data_Bus   (Can_tx_data_Bus),
    .Can_tx_data_valid (Can_tx_data_valid),
    .Can_tx_data_ready (Can_tx_data_ready),
    .Can_tx            (Can_tx),
    .Can_tx_busy       (Can_tx_busy),
    .Can_tx_done       (Can_tx_done),
    .Can_tx_error      (Can_tx_error),
    .statev            (statev)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: fields laid out in order, CRC = remainder of M(x)*x^15 / G(x).
  function automatic exp_t model(input logic [10:0] id, input logic [3:0] dlc,
                                 input logic [7:0] d [8], input int supplied);
    exp_t         e;
    int           n;
    int           nb;
    logic [191:0] msg;
    logic [7:0]   ctrl;
    e.bits  = '0;
    e.kind  = K_DONE;
    ctrl    = {4'b0000, dlc};
    e.bits[0] = 1'b0;
    n = 1;
    for (int i = 10; i >= 0; i--) begin e.bits[n] = id[i]; n++; end
    for (int i = 7; i >= 0; i--) begin e.bits[n] = ctrl[i]; n++; end
    nb = (dlc > 4'd8) ? 8 : int'(dlc);
    for (int b = 0; b < nb; b++) begin
      if (b >= supplied) begin
        e.bits[n] = 1'b1;
        e.nbits   = n + 1;
        e.kind    = K_ERR;
        return e;
      end
      for (int i = 7; i >= 0; i--) begin e.bits[n] = d[b][i]; n++; end
    end
    msg = '0;
    for (int i = 0; i < n; i++) msg[i] = e.bits[i];
    for (int i = 0; i < n; i++) begin
      if (msg[i]) begin
        msg[i] = 1'b0;
        for (int j = 0; j < 15; j++) msg[i+1+j] = msg[i+1+j] ^ poly_v[14-j];
      end
    end
    for (int j = 0; j < 15; j++) e.bits[n+j] = msg[n+j];
    n += 15;
    // ACK, seven EOF ones, and the completing strobe which leaves the line at 1.
    for (int j = 0; j < 9; j++) e.bits[n+j] = 1'b1;
    e.nbits = n + 9;
    return e;
  endfunction

  // Strobe generator: every cycle, or roughly one cycle in three.
  initial forever begin
    @(posedge clock); #1;
    T_frame = rnd_strobe ? ($urandom_range(0, 2) == 0) : 1'b1;
  end

  // Byte feeder: offers the head of feed_q whenever it holds something.
  initial begin : feeder
    bit hs;
    forever begin
      @(negedge clock);
      hs = Can_tx_data_valid && Can_tx_data_ready && !reset;
      @(posedge clock); #1;
      if (hs && feed_q.size() > 0) void'(feed_q.pop_front());
      Can_tx_data_valid = (feed_q.size() > 0);
      if (feed_q.size() > 0) Can_tx_data_Bus = feed_q[0];
    end
  end

  // Monitor: T_frame/busy seen at a negedge apply to the following posedge.
  initial begin : monitor
    exp_t         e;
    logic [255:0] cap;
    int           cap_n;
    int           mm;
    int           expv;
    bit           tf_prev, busy_prev, rst_prev;
    cap = '0; cap_n = 0; tf_prev = 0; busy_prev = 0; rst_prev = 0;
    forever begin
      @(negedge clock);
      if (rst_prev) begin
        check("rst_tx", Can_tx, 1);
        check("rst_busy", Can_tx_busy, 0);
        check("rst_ready", Can_tx_data_ready, 1);
        check("rst_done", Can_tx_done, 0);
        check("rst_error", Can_tx_error, 0);
        check("rst_statev", statev, 0);
        if (exp_q.size() > 0 && exp_q[0].kind == K_ABORT) begin
          e  = exp_q.pop_front();
          mm = 0;
          for (int i = 0; i < cap_n; i++) if (cap[i] !== e.bits[i]) mm++;
          check("abort_prefix_bits", mm, 0);
          check("abort_had_bits", int'(cap_n > 8), 1);
        end
        cap_n = 0;
      end else begin
        if (tf_prev && busy_prev) begin
          if (cap_n < 256) cap[cap_n] = Can_tx;
          cap_n++;
        end else begin
          expv = (cap_n > 0 && exp_q.size() > 0) ? int'(exp_q[0].bits[cap_n-1]) : 1;
          check("tx_steady_between_strobes", Can_tx, expv);
        end
        if (Can_tx_done || Can_tx_error) begin
          check("busy_drops_with_pulse", Can_tx_busy, 0);
          check("ready_after_end", Can_tx_data_ready, 1);
          if (exp_q.size() == 0) begin
            check("unexpected_end_pulse", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("end_kind_done", Can_tx_done, int'(e.kind == K_DONE));
            check("end_kind_error", Can_tx_error, int'(e.kind == K_ERR));
            check("frame_strobe_count", cap_n, e.nbits);
            mm = 0;
            for (int i = 0; i < e.nbits && i < 256; i++) if (cap[i] !== e.bits[i]) mm++;
            check("frame_bits", mm, 0);
          end
          cap_n = 0;
        end
      end
      tf_prev   = T_frame;
      busy_prev = Can_tx_busy;
      rst_prev  = reset;
    end
  end

  task automatic wait_idle();
    bit got = 0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clock);
      got = !Can_tx_busy;
    end
    check("idle_before_start", got, 1);
  endtask

  task automatic send_frame(input logic [10:0] id, input logic [3:0] dlc,
                            input logic [7:0] d [8], input int supplied,
                            input bit hold, input bit rnd, input bit abort);
    exp_t e;
    int   nb;
    bit   got;
    wait_idle();
    e = model(id, dlc, d, supplied);
    if (abort) e.kind = K_ABORT;
    exp_q.push_back(e);
    nb = (dlc > 4'd8) ? 8 : int'(dlc);
    for (int i = 0; i < supplied && i < nb; i++) feed_q.push_back(d[i]);
    rnd_strobe = rnd;
    @(posedge clock); #1;
    Can_tx_id    = id;
    Can_tx_dlc   = dlc;
    Can_tx_start = 1'b1;
    @(posedge clock); #1;
    if (hold) begin
      Can_tx_id  = ~id;
      Can_tx_dlc = dlc ^ 4'h5;
    end else begin
      Can_tx_start = 1'b0;
    end
    @(negedge clock);
    check("busy_after_start", Can_tx_busy, 1);
    got = 0;
    if (abort) begin
      for (int c = 0; c < 3000 && !got; c++) begin
        @(negedge clock);
        got = (statev == 4'd4);
      end
      check("reached_data_state", got, 1);
      repeat (6) @(posedge clock);
      #1;
      reset = 1'b1;
      feed_q.delete();
      Can_tx_data_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
    end else begin
      for (int c = 0; c < 3000 && !got; c++) begin
        @(negedge clock);
        got = Can_tx_done || Can_tx_error;
      end
      Can_tx_start = 1'b0;
      check("frame_end_seen", got, 1);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [7:0] d [8];
    logic [7:0] z [8];
    for (int i = 0; i < 8; i++) begin
      d[i] = 8'h41 + 8'(i);
      z[i] = 8'h00;
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // All-zero frame: CRC remains 0.
    send_frame(11'h000, 4'd0, z, 0, 1'b0, 1'b0, 1'b0);
    // Full frame "ABCDEFGH" with maximal ID.
    send_frame(11'h7FF, 4'd8, d, 8, 1'b0, 1'b1, 1'b0);
    // Underrun on the second byte, then a normal frame.
    send_frame(11'h123, 4'd2, d, 1, 1'b0, 1'b1, 1'b0);
    send_frame(11'h456, 4'd3, d, 3, 1'b0, 1'b0, 1'b0);
    // DLC clamp.
    send_frame(11'h2A5, 4'hF, d, 8, 1'b0, 1'b1, 1'b0);
    // Reset in DATA, then a bit-exact frame.
    send_frame(11'h3C3, 4'd8, d, 8, 1'b0, 1'b1, 1'b1);
    send_frame(11'h0F0, 4'd5, d, 5, 1'b0, 1'b1, 1'b0);
    // Start held for the whole frame with strobes every cycle.
    send_frame(11'h555, 4'd2, d, 2, 1'b1, 1'b0, 1'b0);
    send_frame(11'h001, 4'd1, d, 1, 1'b1, 1'b1, 1'b0);

    for (int f = 0; f < 6; f++) begin
      logic [7:0]  r [8];
      logic [3:0]  rd;
      int          nb;
      for (int i = 0; i < 8; i++) r[i] = 8'($urandom);
      rd = 4'($urandom_range(0, 15));
      nb = (rd > 4'd8) ? 8 : int'(rd);
      send_frame(11'($urandom), rd, r, nb, bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), 1'b0);
    end

    repeat (20) @(posedge clock);
    @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    check("idle_line_high", Can_tx, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
